dphy_hs_byte_tx: RTL and testbench
==================================

// Module: dphy_hs_byte_tx
// PURPOSE
//  Transmit-side D-PHY HS byte engine: accepts 32-bit CSI-2 packet words (valid/ready/last), runs lane HS entry,
//  inserts the 0xB8 sync byte on every lane, stripes payload bytes across lanes and generates HS trail and exit.
//  Sits between the CSI-2 packet builder and the per-lane OSERDES wrappers; one byte clock domain.
// PARAMETERS
//  DATA_LANES  2  active lanes; legal values 1, 2, 4
//  T_PREP      4  byte clocks of HS-prepare/zero (hs_req_o=1, no valid data) before the sync byte; >=1
//  T_TRAIL     4  byte clocks of HS-trail after the final payload byte; >=1
//  T_LPX       2  byte clocks forced in LP (hs_req_o=0) after trail before the next packet may start; >=1
// PORTS
//  clk_i         in   1              byte clock; single clock
//  rst_n_i       in   1              reset: asynchronous assert, active-low
//  enable_i      in   1              sampled in IDLE only; 0 keeps block in IDLE
//  data_i        in   32             packet word, byte0 = data_i[7:0] transmitted first
//  valid_i       in   1              data_i valid
//  last_i        in   1              data_i is final word of packet
//  ready_o       out  1              word accepted on valid_i & ready_o
//  hs_req_o      out  1              lanes requested in HS mode
//  byte_data_o   out  DATA_LANES*8   [DATA_LANES-1:0][7:0] byte per lane to serializers
//  byte_valid_o  out  1              serializers drive byte_data_o this cycle
//  busy_o        out  1              state != IDLE
//  underflow_o   out  1              1-cycle pulse: word needed mid-packet but valid_i=0
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, counters 0; async assertion mid-packet drops hs_req_o immediately, word discarded.
//  SLOTS = 4/DATA_LANES; slot s puts byte s*DATA_LANES+i of held word on lane i (2 lanes: lane0=b0,lane1=b1 then b2,b3).
//  FSM (all transitions registered):
//   IDLE:    enable_i & valid_i -> PREP. ready_o=0. No word consumed in IDLE.
//   PREP:    hs_req_o=1, byte_valid_o=0, bytes 0x00; T_PREP cycles -> SYNC.
//   SYNC:    1 cycle; all lanes 0xB8, byte_valid_o=1; ready_o=1, first word captured (valid_i held since IDLE) -> DATA.
//   DATA:    byte_valid_o=1, slot counter 0..SLOTS-1; at final slot: if held word flagged last -> TRAIL;
//            else ready_o=1: valid_i=1 captures next word, slot wraps to 0; valid_i=0 -> underflow_o pulse, -> TRAIL.
//   TRAIL:   T_TRAIL cycles, byte_valid_o=1; lane i drives {8{~b7}} where b7 = bit 7 of lane i's last sent byte -> EXIT.
//   EXIT:    hs_req_o=0, byte_valid_o=0; T_LPX cycles -> IDLE. enable_i/valid_i ignored.
//  ready_o is combinational from state/slot only (never from valid_i); asserted only in SYNC or DATA final slot.
//  hs_req_o=1 in PREP,SYNC,DATA,TRAIL. Latency: valid_i in IDLE -> sync byte exactly T_PREP+1 cycles later.
//  DATA_LANES=4: SLOTS=1, word accepted every DATA cycle. Single-word packet: SYNC, SLOTS DATA cycles, TRAIL.
//  enable_i deassert mid-packet has no effect; packet completes. Underflow in SYNC impossible by contract.
//  byte_data_o outside SYNC/DATA/TRAIL = 0. Counters sized $clog2(max(T_*)+1), saturate-free wrap not used.
// STRUCTURE
//  dphy_tx_pkg: SYNC_BYTE=8'hB8, state enum tx_state_t {IDLE,PREP,SYNC,DATA,TRAIL,EXIT}, lane-byte typedef.
//  Sub-module dphy_tx_word_split: combinational slot mux word+slot -> [DATA_LANES-1:0][7:0].
//  Top holds FSM, timing counter, word/last holding registers, trail-bit capture.
// TESTING
//  1) DATA_LANES=2, 1 word 0x44332211 last -> PREP 4 cyc, lanes {B8,B8}, {22,11}, {44,33}, trail {FF,FF}x4, LP 2.
//  2) DATA_LANES=4, 3 words back-to-back -> ready_o 1 in SYNC and 2 DATA cycles, no gaps, underflow_o never.
//  3) DATA_LANES=2, valid_i low at 2nd-word fetch -> underflow_o 1 cycle, TRAIL follows, next packet sends normally.
//  4) Last bytes 0x80/0x01 on lanes 1/0 -> trail lane1=0x00, lane0=0xFF for T_TRAIL cycles.
//  5) rst_n_i low during DATA -> same-cycle hs_req_o=0, all outputs 0; after release waits in IDLE for valid_i.
//  6) enable_i=0 with valid_i=1 -> stays IDLE, ready_o=0; enable_i low mid-packet -> packet completes.

Source files
------------

// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY HS byte transmitter.
// Sync byte value, FSM state encoding and the per-lane byte type.
package dphy_tx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SYNC,
        DATA,
        TRAIL,
        EXIT
    } tx_state_t;

    typedef logic [7:0] lane_byte_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dphy_tx_word_split.sv
// Slot multiplexer: picks the bytes of the held 32-bit word that go
// out on each lane for the current slot (slot s, lane i -> byte s*L+i).
module dphy_tx_word_split
    import dphy_tx_pkg::*;
#(
    parameter int DATA_LANES = 2,
    parameter int SW         = 1
) (
    input  logic [31:0]              word_i,
    input  logic [SW-1:0]            slot_i,
    output logic [DATA_LANES*8-1:0]  lanes_o
);

    lane_byte_t [3:0] wbytes;

    assign wbytes = word_i;

    // Route byte slot*DATA_LANES+i of the word onto lane i
    always_comb begin
        lanes_o = '0;
        for (int i = 0; i < DATA_LANES; i++) begin
            lanes_o[i*8 +: 8] = wbytes[2'(int'(slot_i) * DATA_LANES + i)];
        end
    end

endmodule

// File: rtl/dphy_hs_byte_tx.sv
// D-PHY HS byte engine: HS entry, sync byte, lane striping of packet
// words, HS trail and forced LP exit, all in the byte clock domain.
module dphy_hs_byte_tx
    import dphy_tx_pkg::*;
#(
    parameter int DATA_LANES = 2,
    parameter int T_PREP     = 4,
    parameter int T_TRAIL    = 4,
    parameter int T_LPX      = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic [31:0]              data_i,
    input  logic                     valid_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic                     hs_req_o,
    output logic [DATA_LANES*8-1:0]  byte_data_o,
    output logic                     byte_valid_o,
    output logic                     busy_o,
    output logic                     underflow_o
);

    localparam int SLOTS = 4 / DATA_LANES;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int TMAX  = max3(T_PREP, T_TRAIL, T_LPX);
    localparam int CW    = $clog2(TMAX + 1);

    tx_state_t                   state_q;
    logic [CW-1:0]               cnt_q;
    logic [SW-1:0]               slot_q;
    logic [31:0]                 word_q;
    logic                        last_q;
    logic [DATA_LANES-1:0]       trail_q;
    logic                        underflow_q;
    logic [DATA_LANES*8-1:0]     split_w;
    lane_byte_t [DATA_LANES-1:0] lanes;
    logic                        slot_last;

    dphy_tx_word_split #(
        .DATA_LANES (DATA_LANES),
        .SW         (SW)
    ) u_split (
        .word_i  (word_q),
        .slot_i  (slot_q),
        .lanes_o (split_w)
    );

    assign lanes     = split_w;
    assign slot_last = (slot_q == SW'(SLOTS - 1));

    // Sequencer: state, phase timer, held word, slot and trail levels
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            trail_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable_i && valid_i) begin
                        state_q <= PREP;
                        cnt_q   <= '0;
                    end
                end
                PREP: begin
                    if (cnt_q == CW'(T_PREP - 1)) begin
                        state_q <= SYNC;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SYNC: begin
                    word_q  <= data_i;
                    last_q  <= last_i;
                    slot_q  <= '0;
                    state_q <= DATA;
                end
                DATA: begin
                    if (!slot_last) begin
                        slot_q <= slot_q + 1'b1;
                    end else if (!last_q && valid_i) begin
                        word_q <= data_i;
                        last_q <= last_i;
                        slot_q <= '0;
                    end else begin
                        state_q     <= TRAIL;
                        cnt_q       <= '0;
                        underflow_q <= !last_q;
                        for (int i = 0; i < DATA_LANES; i++) begin
                            trail_q[i] <= ~lanes[i][7];
                        end
                    end
                end
                TRAIL: begin
                    if (cnt_q == CW'(T_TRAIL - 1)) begin
                        state_q <= EXIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                EXIT: begin
                    if (cnt_q == CW'(T_LPX - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Lane outputs decoded purely from registered state
    always_comb begin
        hs_req_o     = 1'b0;
        byte_valid_o = 1'b0;
        byte_data_o  = '0;
        ready_o      = 1'b0;
        unique case (state_q)
            PREP: begin
                hs_req_o = 1'b1;
            end
            SYNC: begin
                hs_req_o     = 1'b1;
                byte_valid_o = 1'b1;
                byte_data_o  = {DATA_LANES{SYNC_BYTE}};
                ready_o      = 1'b1;
            end
            DATA: begin
                hs_req_o     = 1'b1;
                byte_valid_o = 1'b1;
                byte_data_o  = split_w;
                ready_o      = slot_last & ~last_q;
            end
            TRAIL: begin
                hs_req_o     = 1'b1;
                byte_valid_o = 1'b1;
                for (int i = 0; i < DATA_LANES; i++) begin
                    byte_data_o[i*8 +: 8] = {8{trail_q[i]}};
                end
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_dphy_hs_byte_tx.sv
// Bench for dphy_hs_byte_tx: 2-lane and 4-lane instances driven from a
// byte-stream reference model of each packet's expected lane activity.
module tb_dphy_hs_byte_tx;

    localparam int T_PREP  = 4;
    localparam int T_TRAIL = 4;
    localparam int T_LPX   = 2;

    typedef struct packed {
        logic [36:0] e;
        logic        en;
        logic        vi;
        logic        li;
        logic [31:0] di;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en2, en4;
    logic [31:0] data;
    logic        valid, last;

    logic        rdy2, hs2, bv2, busy2, uf2;
    logic [15:0] d2;
    logic        rdy4, hs4, bv4, busy4, uf4;
    logic [31:0] d4;

    logic [31:0] words [8];
    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    dphy_hs_byte_tx #(
        .DATA_LANES (2),
        .T_PREP     (T_PREP),
        .T_TRAIL    (T_TRAIL),
        .T_LPX      (T_LPX)
    ) u_dut2 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (en2),
        .data_i       (data),
        .valid_i      (valid),
        .last_i       (last),
        .ready_o      (rdy2),
        .hs_req_o     (hs2),
        .byte_data_o  (d2),
        .byte_valid_o (bv2),
        .busy_o       (busy2),
        .underflow_o  (uf2)
    );

    dphy_hs_byte_tx #(
        .DATA_LANES (4),
        .T_PREP     (T_PREP),
        .T_TRAIL    (T_TRAIL),
        .T_LPX      (T_LPX)
    ) u_dut4 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (en4),
        .data_i       (data),
        .valid_i      (valid),
        .last_i       (last),
        .ready_o      (rdy4),
        .hs_req_o     (hs4),
        .byte_data_o  (d4),
        .byte_valid_o (bv4),
        .busy_o       (busy4),
        .underflow_o  (uf4)
    );

    // {busy, hs_req, byte_valid, ready, underflow, lane bytes}
    function automatic logic [36:0] obs(input bit sel);
        if (sel) return {busy4, hs4, bv4, rdy4, uf4, d4};
        return {busy2, hs2, bv2, rdy2, uf2, 16'h0, d2};
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [36:0] o, input logic [36:0] e);
        ntot++;
        assert (o === e) npass++;
        else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, o, e);
        end
    endtask

    // Builds the expected cycle sequence for one packet, then plays it.
    // nw: packet length, prov: words actually offered (prov<nw underflows).
    task automatic run_pkt(input bit sel, input int nw, input int prov,
                           input bit en_mid, input int abort_c,
                           input string tag);
        step_t       q[$];
        step_t       s;
        logic [7:0]  bq[$];
        logic [7:0]  b;
        logic [31:0] d;
        int          L, ng, k;
        bit          eow, rdy;
        L = sel ? 4 : 2;
        s.e  = '0;
        s.en = 1'b1;
        s.vi = 1'b1;
        s.di = words[0];
        s.li = (nw == 1);
        q.push_back(s);
        s.en = en_mid;
        for (int i = 0; i < T_PREP; i++) begin
            s.e = {5'b11000, 32'h0};
            q.push_back(s);
        end
        d = '0;
        for (int i = 0; i < L; i++) d[8*i +: 8] = 8'hB8;
        s.e = {5'b11110, d};
        q.push_back(s);
        for (int w = 0; w < prov; w++)
            for (int j = 0; j < 4; j++) bq.push_back(words[w][8*j +: 8]);
        ng = prov * 4 / L;
        for (int g = 0; g < ng; g++) begin
            d = '0;
            for (int i = 0; i < L; i++) d[8*i +: 8] = bq[g*L + i];
            k   = (g * L) / 4;
            eow = (((g + 1) * L) % 4) == 0;
            rdy = eow && (k < nw - 1);
            s.e = {3'b111, rdy, 1'b0, d};
            if (rdy && (k + 1 < prov)) begin
                s.vi = 1'b1;
                s.di = words[k+1];
                s.li = (k + 1 == nw - 1);
            end else begin
                s.vi = 1'b0;
                s.di = $urandom;
                s.li = 1'($urandom);
            end
            q.push_back(s);
        end
        d = '0;
        for (int i = 0; i < L; i++) begin
            b = bq[bq.size() - L + i];
            d[8*i +: 8] = b[7] ? 8'h00 : 8'hFF;
        end
        s.vi = 1'b0;
        s.li = 1'b0;
        for (int t = 0; t < T_TRAIL; t++) begin
            s.e = {3'b111, 1'b0, (t == 0) && (prov < nw), d};
            q.push_back(s);
        end
        for (int t = 0; t < T_LPX; t++) begin
            s.e = {5'b10000, 32'h0};
            q.push_back(s);
        end
        s.e = '0;
        q.push_back(s);
        foreach (q[c]) begin
            @(negedge clk);
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst"}, c, obs(sel), '0);
                return;
            end
            chk(tag, c, obs(sel), q[c].e);
            if (sel) en4 = q[c].en;
            else en2 = q[c].en;
            valid = q[c].vi;
            data  = q[c].di;
            last  = q[c].li;
        end
        en2   = 1'b0;
        en4   = 1'b0;
        valid = 1'b0;
    endtask

    initial begin
        int nw, prov;
        bit sel;
        rst_n = 1'b0;
        en2   = 1'b0;
        en4   = 1'b0;
        data  = '0;
        valid = 1'b0;
        last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset2", 0, obs(1'b0), '0);
        chk("reset4", 0, obs(1'b1), '0);
        rst_n = 1'b1;
        @(negedge clk);

        words[0] = 32'h44332211;
        run_pkt(1'b0, 1, 1, 1'b1, -1, "t1_single");

        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_pkt(1'b1, 3, 3, 1'b1, -1, "t2_lanes4");

        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_pkt(1'b0, 3, 1, 1'b1, -1, "t3_underflow");
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        run_pkt(1'b0, 2, 2, 1'b1, -1, "t3_next");

        words[0] = 32'h80015A5A;
        run_pkt(1'b0, 1, 1, 1'b1, -1, "t4_trail");

        data  = $urandom;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_disabled", i, obs(1'b0), '0);
        end
        valid = 1'b0;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        run_pkt(1'b0, 2, 2, 1'b0, -1, "t6_en_drop");

        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_pkt(1'b0, 3, 3, 1'b1, T_PREP + 3, "t5_abort");
        @(negedge clk);
        en2   = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en2   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_idle", i, obs(1'b0), '0);
        end
        en2 = 1'b0;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        run_pkt(1'b0, 2, 2, 1'b1, -1, "t5_after");

        for (int r = 0; r < 10; r++) begin
            sel  = 1'($urandom);
            nw   = $urandom_range(1, 4);
            prov = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nw) : nw;
            for (int i = 0; i < nw; i++) words[i] = $urandom;
            run_pkt(sel, nw, prov, 1'($urandom), -1, "rnd");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
